// File: rtl/uart_rx_byte.sv
// UART receive front end: 8N1 frames, LSB first, one-cycle RX_valid / RX_frame_err strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] RX_byte,
  output logic       RX_valid,
  output logic       RX_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER} state_t;
`endif

  state_t           state_reg, state_next;
  logic [1:0]       sync_reg;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       byte_reg, byte_next;
  logic             valid_reg, valid_next;
  logic             frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_reg, parity_err_next;
`endif

  assign rx_s         = sync_reg[1];
  assign RX_byte      = byte_reg;
  assign RX_valid     = valid_reg;
  assign RX_frame_err = frame_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg      <= 2'b11;
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      byte_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      sync_reg      <= {sync_reg[0], rx_serial};
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      byte_reg      <= byte_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  // cnt_reg counts cycles since the previous sample point (or since t=1 in START).
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    byte_next      = byte_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_next = parity_err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_DATA;
            bit_idx_next = 4'd1;
          end
        end
      end
      S_DATA: begin
        if (cnt_reg == BIT_M1) begin
          cnt_next = '0;
          // index 8 wraps to position 7 in the 3-bit subtraction
          shift_next[bit_idx_reg[2:0] - 3'd1] = rx_s;
          bit_idx_next = bit_idx_reg + 4'd1;
          if (bit_idx_reg == 4'd8) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_reg == BIT_M1) begin
          cnt_next        = '0;
          parity_err_next = rx_s ^ (^shift_reg);
          state_next      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_reg == BIT_M1) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_err_reg) begin
              frame_err_next = 1'b1;
            end else begin
              valid_next = 1'b1;
              byte_next  = shift_reg;
            end
`else
            valid_next = 1'b1;
            byte_next  = shift_reg;
`endif
          end else begin
            frame_err_next = 1'b1;
            state_next     = S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        cnt_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLKS_PER_BIT=16; a negedge monitor records every strobe.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + 8 + 10 * CPB + 1;
`else
  localparam int LAT = 2 + 8 + 9 * CPB + 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] RX_byte;
  logic       RX_valid;
  logic       RX_frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int v_cnt = 0, e_cnt = 0;
  int last_v_cyc = 0, prev_v_cyc = 0, last_e_cyc = 0;
  logic [7:0] last_v_byte = 8'h00, prev_v_byte = 8'h00;
  int fall_cyc = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx_serial(rx_serial),
    .RX_byte(RX_byte), .RX_valid(RX_valid), .RX_frame_err(RX_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (RX_valid) begin
      prev_v_cyc = last_v_cyc; prev_v_byte = last_v_byte;
      last_v_cyc = cyc; last_v_byte = RX_byte; v_cnt++;
      $display("[TB] cyc %0d RX_valid byte=%02h", cyc, RX_byte);
    end
    if (RX_frame_err) begin
      last_e_cyc = cyc; e_cnt++;
      $display("[TB] cyc %0d RX_frame_err", cyc);
    end
    if (RX_valid && RX_frame_err) begin
      n_fail++;
      $display("FAIL exclusive: valid=%b err=%b required not both 1", RX_valid, RX_frame_err);
    end
  end

  // All stimulus changes happen on falling edges; callers start aligned to a negedge.
  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_b);
    rx_serial = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_byte(input string name, input logic [7:0] b, input int v0, input int e0);
    n_tests++;
    if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL %s count: got %0d valid pulses, expected 1", name, v_cnt - v0); end
    n_tests++;
    if (last_v_byte !== b) begin n_fail++; $display("FAIL %s byte: got %02h, expected %02h", name, last_v_byte, b); end
    n_tests++;
    if (last_v_cyc - fall_cyc !== LAT) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", name, last_v_cyc - fall_cyc, LAT); end
    n_tests++;
    if (e_cnt - e0 !== 0) begin n_fail++; $display("FAIL %s err: got %0d err pulses, expected 0", name, e_cnt - e0); end
    $display("[TB] %s: byte %02h checked", name, b);
  endtask

  task automatic test_reset();
    int v0, e0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (RX_byte !== 8'h00) begin n_fail++; $display("FAIL reset byte: got %02h, expected 00", RX_byte); end
    n_tests++;
    if (RX_valid !== 1'b0 || RX_frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset strobes: got valid=%b err=%b, expected 0 0", RX_valid, RX_frame_err);
    end
    v0 = v_cnt; e0 = e_cnt;
    idle(200);
    n_tests++;
    if (v_cnt != v0 || e_cnt != e0) begin
      n_fail++; $display("FAIL reset idle: got %0d/%0d strobes, expected 0/0", v_cnt - v0, e_cnt - e0);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    int v0 = v_cnt, e0 = e_cnt;
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(10);
    expect_byte("single", 8'h3C, v0, e0);
  endtask

  task automatic test_back_to_back();
    int v0 = v_cnt, e0 = e_cnt;
    send_frame(8'h36, 1'b1, 1'b0);
    send_frame(8'h31, 1'b1, 1'b0);
    idle(10);
    expect_byte("b2b_second", 8'h31, v0 + 1, e0);
    n_tests++;
    if (prev_v_byte !== 8'h36) begin n_fail++; $display("FAIL b2b first byte: got %02h, expected 36", prev_v_byte); end
    n_tests++;
    if (last_v_cyc - prev_v_cyc !== 10 * CPB + ((LAT > 155) ? CPB : 0)) begin
      n_fail++; $display("FAIL b2b spacing: got %0d, expected %0d", last_v_cyc - prev_v_cyc, 10 * CPB + ((LAT > 155) ? CPB : 0));
    end
  endtask

  task automatic test_glitch();
    int v0 = v_cnt, e0 = e_cnt;
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    n_tests++;
    if (v_cnt != v0 || e_cnt != e0) begin
      n_fail++; $display("FAIL glitch strobe: got %0d/%0d, expected 0/0", v_cnt - v0, e_cnt - e0);
    end
    send_frame(8'h2B, 1'b1, 1'b0);
    idle(10);
    expect_byte("after_glitch", 8'h2B, v0, e0);
  endtask

  task automatic test_frame_err();
    int v0 = v_cnt, e0 = e_cnt;
    send_frame(8'h2D, 1'b0, 1'b0);
    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    n_tests++;
    if (e_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr count: got %0d, expected 1", e_cnt - e0); end
    n_tests++;
    if (last_e_cyc - fall_cyc !== LAT) begin n_fail++; $display("FAIL ferr latency: got %0d, expected %0d", last_e_cyc - fall_cyc, LAT); end
    n_tests++;
    if (v_cnt != v0) begin n_fail++; $display("FAIL ferr valid: got %0d pulses, expected 0", v_cnt - v0); end
    n_tests++;
    if (RX_byte !== 8'h2B) begin n_fail++; $display("FAIL ferr hold: got %02h, expected 2B", RX_byte); end
    idle(20);
    n_tests++;
    if (e_cnt - e0 !== 1 || v_cnt != v0) begin
      n_fail++; $display("FAIL ferr recover: got %0d err %0d valid, expected 1 0", e_cnt - e0, v_cnt - v0);
    end
    send_frame(8'h3E, 1'b1, 1'b0);
    idle(10);
    expect_byte("after_ferr", 8'h3E, v0, e0 + 1);
  endtask

  task automatic test_reset_mid();
    int v0 = v_cnt, e0 = e_cnt;
    fall_cyc = cyc;
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    rx_serial = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1; rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (RX_byte !== 8'h00 || RX_valid !== 1'b0 || RX_frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset outputs: got byte=%02h v=%b e=%b, expected 00 0 0", RX_byte, RX_valid, RX_frame_err);
    end
    reset = 1'b0;
    idle(200);
    n_tests++;
    if (v_cnt != v0 || e_cnt != e0) begin
      n_fail++; $display("FAIL midreset strobe: got %0d/%0d, expected 0/0", v_cnt - v0, e_cnt - e0);
    end
    send_frame(8'h30, 1'b1, 1'b0);
    idle(10);
    expect_byte("after_midreset", 8'h30, v0, e0);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0 = v_cnt, e0 = e_cnt;
    send_frame(8'h31, 1'b1, 1'b1);
    idle(10);
    n_tests++;
    if (e_cnt - e0 !== 1) begin n_fail++; $display("FAIL parity err: got %0d, expected 1", e_cnt - e0); end
    n_tests++;
    if (v_cnt != v0) begin n_fail++; $display("FAIL parity valid: got %0d, expected 0", v_cnt - v0); end
    send_frame(8'h31, 1'b1, 1'b0);
    idle(10);
    expect_byte("parity_ok", 8'h31, v0, e0 + 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
